// File: rtl/cpu_pkg.sv
// Shared CPU types for the operand2 shift stage: shift ops, decode forms,
// stage states, operand2 field positions. With SHIFT_CARRY_EN defined, it also
// provides the ARM shifter carry-out helper.
package cpu_pkg;

    typedef enum logic [1:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROR} shift_op_e;
    typedef enum logic [1:0] {FORM_IMM, FORM_ISH, FORM_RSH} form_e;
    typedef enum logic [1:0] {IDLE, RS_WAIT, OUT} state_e;

    // operand2 field positions
    localparam int OP2_I_BIT    = 25;   // 1: rotated immediate
    localparam int OP2_REG_BIT  = 4;    // 1: shift amount from Rs
    localparam int OP2_B7_BIT   = 7;    // must be 0 for register-specified shift
    localparam int OP2_SHOP_LSB = 5;    // [6:5] shift type
    localparam int OP2_AMT5_LSB = 7;    // [11:7] immediate shift amount
    localparam int OP2_RS_LSB   = 8;    // [11:8] Rs
    localparam int OP2_ROT_LSB  = 8;    // [11:8] immediate rotate / 2
    localparam int OP2_IMM_LSB  = 0;    // [7:0] immediate byte

`ifdef SHIFT_CARRY_EN
    // ARM shifter carry-out. n is the architectural amount (Rs[7:0] for the
    // register form), so ROR by a non-zero multiple of 32 yields x[31].
    function automatic logic shift_carry(input logic [31:0] x, input logic [1:0] op,
                                         input logic [8:0] n, input logic is_rrx,
                                         input logic cin);
        logic [4:0] k;
        logic       c;
        k = 5'(n - 9'd1);
        if (is_rrx)
            c = x[0];
        else if (n == 9'd0)
            c = cin;
        else begin
            case (shift_op_e'(op))
                SH_LSL:  c = (n <= 9'd32) ? x[5'(9'd32 - n)] : 1'b0;
                SH_LSR:  c = (n <= 9'd32) ? x[k] : 1'b0;
                SH_ASR:  c = (n >= 9'd32) ? x[31] : x[k];
                default: c = x[k];
            endcase
        end
        return c;
    endfunction
`endif

endpackage

// File: rtl/shift_amt_decode.sv
// Combinational mapping of the operand2 form, shift type and raw amount to the
// barrel-shifter op/amount and the RRX flag.
module shift_amt_decode
    import cpu_pkg::*;
#(
    parameter int AMT_W = 32
) (
    input  logic [1:0]       form,
    input  logic [1:0]       op_in,
    input  logic [4:0]       amt5,
    input  logic [7:0]       rs8,
    output logic [1:0]       sh_op,
    output logic [AMT_W-1:0] sh_amt,
    output logic             rrx
);

    // Immediate: ROR by 2*rot; imm-shift: #0 encodings remapped; reg: Rs byte
    always_comb begin
        sh_op  = op_in;
        sh_amt = '0;
        rrx    = 1'b0;
        case (form)
            FORM_IMM: begin
                sh_op  = SH_ROR;
                sh_amt = AMT_W'(amt5);
            end
            FORM_RSH: begin
                sh_amt = (op_in == SH_ROR) ? AMT_W'(rs8[4:0]) : AMT_W'(rs8);
            end
            default: begin
                if (amt5 == 5'd0) begin
                    case (op_in)
                        SH_LSL:  sh_amt = '0;
                        SH_ROR: begin
                            rrx    = 1'b1;
                            sh_amt = AMT_W'(1);
                        end
                        default: sh_amt = AMT_W'(32);
                    endcase
                end else begin
                    sh_amt = AMT_W'(amt5);
                end
            end
        endcase
    end

endmodule

// File: rtl/shift_operand_stage.sv
// Operand2 decode stage: turns a data-processing instruction plus Rm into
// barrel-shifter controls. Register-specified shifts spend one extra cycle
// reading Rs. Single-entry output buffer with valid/ready on both sides.
// Optional SHIFT_CARRY_EN adds the registered shifter carry-out sh_cout.
module shift_operand_stage
    import cpu_pkg::*;
#(
    parameter int AMT_W  = 32,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [31:0]       rm_data,
    input  logic              c_flag,
    output logic [REG_AW-1:0] rs_addr,
    output logic              rs_rd_en,
    input  logic [31:0]       rs_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       sh_in,
    output logic [1:0]        sh_op,
    output logic [AMT_W-1:0]  sh_amt,
    output logic              rrx,
    output logic              rrx_cin
`ifdef SHIFT_CARRY_EN
    ,
    output logic              sh_cout
`endif
);

    state_e            state_q, state_d;
    logic              acc, is_rsh, is_imm;
    logic [REG_AW-1:0] rs_addr_q;
    logic [1:0]        dec_form, dec_op_in, dec_op;
    logic [4:0]        dec_amt5;
    logic [AMT_W-1:0]  dec_amt;
    logic              dec_rrx;
    logic [31:0]       sh_in_d;
    logic              unused_bits;

    assign unused_bits = ^{instr[31:26], instr[24:12], rs_data[31:8]};

    assign is_imm    = instr[OP2_I_BIT];
    assign is_rsh    = ~instr[OP2_I_BIT] & ~instr[OP2_B7_BIT] & instr[OP2_REG_BIT];
    assign in_ready  = (state_q == IDLE) | ((state_q == OUT) & out_ready);
    assign acc       = in_valid & in_ready;
    assign out_valid = (state_q == OUT);
    assign rs_rd_en  = acc & is_rsh;
    assign rs_addr   = rs_rd_en ? REG_AW'(instr[OP2_RS_LSB +: 4]) : rs_addr_q;
    assign sh_in_d   = is_imm ? {24'b0, instr[OP2_IMM_LSB +: 8]} : rm_data;

    // Decoder inputs: live instruction fields, or the held op plus Rs in RS_WAIT
    always_comb begin
        dec_form  = FORM_ISH;
        dec_op_in = instr[OP2_SHOP_LSB +: 2];
        dec_amt5  = instr[OP2_AMT5_LSB +: 5];
        if (state_q == RS_WAIT) begin
            dec_form  = FORM_RSH;
            dec_op_in = sh_op;
            dec_amt5  = '0;
        end else if (is_imm) begin
            dec_form = FORM_IMM;
            dec_amt5 = {instr[OP2_ROT_LSB +: 4], 1'b0};
        end else if (is_rsh) begin
            dec_form = FORM_RSH;
        end
    end

    shift_amt_decode #(.AMT_W(AMT_W)) u_dec (
        .form   (dec_form),
        .op_in  (dec_op_in),
        .amt5   (dec_amt5),
        .rs8    (rs_data[7:0]),
        .sh_op  (dec_op),
        .sh_amt (dec_amt),
        .rrx    (dec_rrx)
    );

    // Next state: register form detours through RS_WAIT; OUT drains on out_ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (acc) state_d = is_rsh ? RS_WAIT : OUT;
            RS_WAIT: state_d = OUT;
            OUT: begin
                if (out_ready) begin
                    if (acc) state_d = is_rsh ? RS_WAIT : OUT;
                    else     state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and output buffer; loads only on accept or Rs arrival,
    // so the buffer holds while out_valid & !out_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rs_addr_q <= '0;
            sh_in     <= '0;
            sh_op     <= '0;
            sh_amt    <= '0;
            rrx       <= 1'b0;
            rrx_cin   <= 1'b0;
`ifdef SHIFT_CARRY_EN
            sh_cout   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == RS_WAIT) begin
                sh_amt <= dec_amt;
                rrx    <= 1'b0;
`ifdef SHIFT_CARRY_EN
                sh_cout <= shift_carry(sh_in, sh_op, {1'b0, rs_data[7:0]}, 1'b0, rrx_cin);
`endif
            end else if (acc) begin
                sh_in   <= sh_in_d;
                sh_op   <= dec_op;
                sh_amt  <= dec_amt;
                rrx     <= dec_rrx;
                rrx_cin <= c_flag;
                if (is_rsh) rs_addr_q <= REG_AW'(instr[OP2_RS_LSB +: 4]);
`ifdef SHIFT_CARRY_EN
                sh_cout <= shift_carry(sh_in_d, dec_op, {3'b0, dec_amt[5:0]}, dec_rrx, c_flag);
`endif
            end
        end
    end

endmodule

// File: tb/tb_shift_operand_stage.sv
// Directed bench for shift_operand_stage; carry checks when SHIFT_CARRY_EN is defined.
module tb_shift_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rm_data;
    logic        c_flag;
    logic [3:0]  rs_addr;
    logic        rs_rd_en;
    logic [31:0] rs_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sh_in;
    logic [1:0]  sh_op;
    logic [31:0] sh_amt;
    logic        rrx;
    logic        rrx_cin;
`ifdef SHIFT_CARRY_EN
    logic        sh_cout;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shift_operand_stage #(.AMT_W(32), .REG_AW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rm_data   (rm_data),
        .c_flag    (c_flag),
        .rs_addr   (rs_addr),
        .rs_rd_en  (rs_rd_en),
        .rs_data   (rs_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sh_in     (sh_in),
        .sh_op     (sh_op),
        .sh_amt    (sh_amt),
        .rrx       (rrx),
        .rrx_cin   (rrx_cin)
`ifdef SHIFT_CARRY_EN
        ,
        .sh_cout   (sh_cout)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] rm, input logic c);
        in_valid = 1'b1;
        instr    = i;
        rm_data  = rm;
        c_flag   = c;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; instr = '0; rm_data = '0; c_flag = 1'b0;
        rs_data = '0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_rs_rd_en", rs_rd_en, 0);
        chk("rst_sh_in", sh_in, 0);
        chk("rst_sh_amt", sh_amt, 0);
        chk("rst_rrx", rrx, 0);
        chk("rst_rs_addr", rs_addr, 0);
        rst_n = 1'b1;
        tick();

        // immediate, rot 0
        drive(32'hE3A000FF, 32'h0, 1'b0);
        #1 chk("imm_rs_rd_en", rs_rd_en, 0);
        tick();
        chk("imm_valid", out_valid, 1);
        chk("imm_sh_in", sh_in, 32'hFF);
        chk("imm_sh_op", sh_op, 3);
        chk("imm_sh_amt", sh_amt, 0);
        chk("imm_rrx", rrx, 0);
`ifdef SHIFT_CARRY_EN
        chk("imm_cout", sh_cout, 0);
`endif
        // immediate rot 4 -> ROR #8, back-to-back
        out_ready = 1'b1;
        drive(32'hE3A004FF, 32'h0, 1'b0);
        tick();
        chk("immrot_sh_amt", sh_amt, 8);
        chk("immrot_sh_in", sh_in, 32'hFF);
`ifdef SHIFT_CARRY_EN
        chk("immrot_cout", sh_cout, 1);
`endif
        // LSR #4
        drive(32'hE1A00221, 32'h80000000, 1'b0);
        tick();
        chk("lsr4_sh_op", sh_op, 1);
        chk("lsr4_sh_amt", sh_amt, 4);
        chk("lsr4_sh_in", sh_in, 32'h80000000);
`ifdef SHIFT_CARRY_EN
        chk("lsr4_cout", sh_cout, 0);
`endif
        // LSR #0 -> 32
        drive(32'hE1A00021, 32'h80000000, 1'b0);
        tick();
        chk("lsr0_sh_amt", sh_amt, 32);
`ifdef SHIFT_CARRY_EN
        chk("lsr0_cout", sh_cout, 1);
`endif
        // ASR #0 -> 32
        drive(32'hE1A00041, 32'h80000000, 1'b0);
        tick();
        chk("asr0_sh_op", sh_op, 2);
        chk("asr0_sh_amt", sh_amt, 32);
        // LSL #0 -> 0, carry passes c_flag
        drive(32'hE1A00001, 32'h80000000, 1'b1);
        tick();
        chk("lsl0_sh_amt", sh_amt, 0);
`ifdef SHIFT_CARRY_EN
        chk("lsl0_cout", sh_cout, 1);
`endif
        // LSL #1 of 0x80000000
        drive(32'hE1A00081, 32'h80000000, 1'b0);
        tick();
        chk("lsl1_sh_amt", sh_amt, 1);
        chk("lsl1_rrx_cin", rrx_cin, 0);
`ifdef SHIFT_CARRY_EN
        chk("lsl1_cout", sh_cout, 1);
`endif
        // ROR #0 -> RRX
        drive(32'hE1A00061, 32'h80000001, 1'b1);
        tick();
        chk("rrx_flag", rrx, 1);
        chk("rrx_cin", rrx_cin, 1);
        chk("rrx_sh_op", sh_op, 3);
        chk("rrx_sh_amt", sh_amt, 1);
`ifdef SHIFT_CARRY_EN
        chk("rrx_cout", sh_cout, 1);
`endif
        in_valid = 1'b0;
        tick();
        chk("drain_valid", out_valid, 0);

        // LSL by R3
        drive(32'hE1A00312, 32'h0000000F, 1'b0);
        #1;
        chk("rsh_rd_en", rs_rd_en, 1);
        chk("rsh_rs_addr", rs_addr, 3);
        chk("rsh_in_ready_idle", in_ready, 1);
        tick();
        in_valid = 1'b0;
        rs_data  = 32'h00000128;
        #1;
        chk("rsh_wait_in_ready", in_ready, 0);
        chk("rsh_wait_valid", out_valid, 0);
        chk("rsh_wait_rd_en", rs_rd_en, 0);
        chk("rsh_addr_held", rs_addr, 3);
        tick();
        chk("rsh_valid", out_valid, 1);
        chk("rsh_sh_amt", sh_amt, 32'h28);
        chk("rsh_sh_op", sh_op, 0);
        chk("rsh_sh_in", sh_in, 32'hF);
`ifdef SHIFT_CARRY_EN
        chk("rsh_cout", sh_cout, 0);
`endif
        // ROR by R3, back-to-back from OUT into RS_WAIT
        drive(32'hE1A00372, 32'h00000010, 1'b0);
        tick();
        in_valid = 1'b0;
        rs_data  = 32'h00000025;
        chk("rror_wait_valid", out_valid, 0);
        tick();
        chk("rror_sh_op", sh_op, 3);
        chk("rror_sh_amt", sh_amt, 5);
        chk("rror_rrx", rrx, 0);
`ifdef SHIFT_CARRY_EN
        chk("rror_cout", sh_cout, 1);
`endif

        // stall 3 cycles with input held
        out_ready = 1'b0;
        drive(32'hE1A00221, 32'h12345678, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", out_valid, 1);
            chk("stall_sh_amt", sh_amt, 5);
            chk("stall_sh_op", sh_op, 3);
            chk("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1 chk("unstall_in_ready", in_ready, 1);
        tick();
        chk("b2b_valid", out_valid, 1);
        chk("b2b_sh_amt", sh_amt, 4);
        chk("b2b_sh_op", sh_op, 1);
        chk("b2b_sh_in", sh_in, 32'h12345678);
`ifdef SHIFT_CARRY_EN
        chk("b2b_cout", sh_cout, 1);
`endif
        in_valid = 1'b0;
        tick();
        chk("idle_valid", out_valid, 0);

        // reset during RS_WAIT
        drive(32'hE1A00312, 32'hDEADBEEF, 1'b1);
        tick();
        in_valid = 1'b0;
        rs_data  = 32'h4;
        rst_n    = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_sh_in", sh_in, 0);
        chk("arst_rrx_cin", rrx_cin, 0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("arst_dropped", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
